// File: rtl/phase_recover.sv
// phase_recover: iterative CORDIC vectoring engine that turns a Q1.14
// (sin, cos) pair into an unsigned phase word. 2^DATA_W counts make one
// full turn, which is the same encoding the Sincos phase input uses.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-low reset
//   in_valid  : sin_in/cos_in pair is valid
//   in_ready  : block can accept a pair (high only while idle)
//   sin_in    : signed Q1.14 sine sample
//   cos_in    : signed Q1.14 cosine sample
//   out_valid : phase_out holds a result
//   out_ready : downstream accepts the result
//   phase_out : unsigned phase, 2^DATA_W counts per turn
//   mag_out   : final CORDIC x, saturated, carrying the ~1.6468 gain
//               (present only with PHASE_RECOVER_MAG_EN defined)
//
// Optional feature macro: PHASE_RECOVER_MAG_EN
module phase_recover #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ITERS  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sin_in,
  input  logic [DATA_W-1:0] cos_in,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PHASE_RECOVER_MAG_EN
  output logic [DATA_W-1:0] phase_out,
  output logic [DATA_W-1:0] mag_out
`else
  output logic [DATA_W-1:0] phase_out
`endif
);

  localparam int unsigned XW       = DATA_W + 2;
  localparam int unsigned CW       = 4;
  localparam int          SCALE_SH = int'(DATA_W) - 16;

  localparam logic [DATA_W-1:0] QUARTER = {2'b01, {(DATA_W-2){1'b0}}};
  localparam logic [DATA_W-1:0] THREE_Q = {2'b11, {(DATA_W-2){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic signed [XW-1:0]    x;
  logic signed [XW-1:0]    y;
  logic [DATA_W-1:0]       z;
  logic [CW-1:0]           cnt;
  logic                    zero_in;

  logic signed [XW-1:0]    cx;
  logic signed [XW-1:0]    sy;
  logic signed [XW-1:0]    px;
  logic signed [XW-1:0]    py;
  logic [DATA_W-1:0]       pz;
  logic signed [XW-1:0]    xs;
  logic signed [XW-1:0]    ys;
  logic [DATA_W-1:0]       ang;

  // atan(2^-i) in turns, tabulated at 2^16 counts per turn and rescaled
  function automatic logic [DATA_W-1:0] atan_lut(input int unsigned i);
    int unsigned v;
    case (i)
      0:       v = 8192;
      1:       v = 4836;
      2:       v = 2555;
      3:       v = 1297;
      4:       v = 651;
      5:       v = 326;
      6:       v = 163;
      7:       v = 81;
      8:       v = 41;
      9:       v = 20;
      10:      v = 10;
      11:      v = 5;
      12:      v = 3;
      13:      v = 1;
      14:      v = 1;
      default: v = 0;
    endcase
    if (SCALE_SH >= 0) return DATA_W'(v << SCALE_SH);
    else               return DATA_W'((v + (32'd1 << (-SCALE_SH - 1))) >> (-SCALE_SH));
  endfunction

  // Quadrant pre-rotation brings the vector into the right half-plane
  always_comb begin
    cx = XW'($signed(cos_in));
    sy = XW'($signed(sin_in));
    px = cx;
    py = sy;
    pz = '0;
    if (cx < 0 && sy >= 0) begin
      px = sy;
      py = -cx;
      pz = QUARTER;
    end else if (cx < 0 && sy < 0) begin
      px = -sy;
      py = cx;
      pz = THREE_Q;
    end
  end

  // Shifted operands and angle step for the current micro-rotation
  always_comb begin
    xs  = x >>> cnt;
    ys  = y >>> cnt;
    ang = atan_lut(32'(cnt));
  end

`ifdef PHASE_RECOVER_MAG_EN
  localparam logic signed [XW-1:0] MAG_MAX = XW'({DATA_W{1'b1}});
`endif

  // Control FSM and datapath; counter value ITERS marks the completion cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      zero_in   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      phase_out <= '0;
`ifdef PHASE_RECOVER_MAG_EN
      mag_out   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x        <= px;
            y        <= py;
            z        <= pz;
            cnt      <= '0;
            zero_in  <= (sin_in == '0) && (cos_in == '0);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt == CW'(ITERS)) begin
            // A (0,0) input has no defined angle; report phase 0
            phase_out <= zero_in ? '0 : z;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef PHASE_RECOVER_MAG_EN
            if (x < 0)             mag_out <= '0;
            else if (x > MAG_MAX)  mag_out <= '1;
            else                   mag_out <= x[DATA_W-1:0];
`endif
          end else begin
            if (y >= 0) begin
              x <= x + ys;
              y <= y - xs;
              z <= z + ang;
            end else begin
              x <= x - ys;
              y <= y + xs;
              z <= z - ang;
            end
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_recover.sv
// Testbench for phase_recover: directed corner cases against known phases,
// handshake/stall/reset behaviour, and randomized pairs against a
// loop-level model of the vectoring algorithm.
module tb_phase_recover;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ITERS  = 14;
  localparam int          LAT    = ITERS + 1;
  localparam real         PI     = 3.14159265358979;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] sin_in = '0;
  logic [DATA_W-1:0] cos_in = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] phase_out;
`ifdef PHASE_RECOVER_MAG_EN
  logic [DATA_W-1:0] mag_out;
`endif

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int atan_tab[16];

  always #5 clk = ~clk;

  phase_recover #(.DATA_W(DATA_W), .ITERS(ITERS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sin_in    (sin_in),
    .cos_in    (cos_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PHASE_RECOVER_MAG_EN
    .phase_out (phase_out),
    .mag_out   (mag_out)
`else
    .phase_out (phase_out)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Circular distance check on the phase wheel
  task automatic check_near(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp, input int tol);
    logic [DATA_W-1:0] d;
    int sd;
    d  = obs - exp;
    sd = int'($signed(d));
    checks++;
    assert (!$isunknown(obs) && sd <= tol && sd >= -tol) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h tol=%0d", tag, obs, exp, tol);
    end
  endtask

  // Reference: quadrant fold, then ITERS shift-and-add rotations on integers
  task automatic ref_model(input int s, input int c, output int ph, output int mg);
    int x, y, z, nx;
    x = c; y = s; z = 0;
    if (c < 0 && s >= 0) begin
      x = s; y = -c; z = 1 << (DATA_W - 2);
    end else if (c < 0 && s < 0) begin
      x = -s; y = c; z = 3 << (DATA_W - 2);
    end
    for (int i = 0; i < int'(ITERS); i++) begin
      if (y >= 0) begin
        nx = x + (y >>> i); y = y - (x >>> i); z = z + atan_tab[i];
      end else begin
        nx = x - (y >>> i); y = y + (x >>> i); z = z - atan_tab[i];
      end
      x = nx;
    end
    ph = (s == 0 && c == 0) ? 0 : (z & ((1 << DATA_W) - 1));
    mg = (x < 0) ? 0 : (x > (1 << DATA_W) - 1) ? (1 << DATA_W) - 1 : x;
  endtask

  // One complete transaction; lat counts edges from accept to out_valid
  task automatic run_pair(input int s, input int c, output logic [DATA_W-1:0] ph,
                          output logic [DATA_W-1:0] mg, output int lat);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    sin_in   = DATA_W'(s);
    cos_in   = DATA_W'(c);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * LAT) begin
      tick();
      lat++;
    end
    ph = phase_out;
`ifdef PHASE_RECOVER_MAG_EN
    mg = mag_out;
`else
    mg = '0;
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] ph, mg, ph0;
    int lat, guard, s, c, eph, emg;
    logic seen_valid;

    for (int i = 0; i < 16; i++)
      atan_tab[i] = $rtoi($atan(2.0 ** (-i)) / (2.0 * PI) * (2.0 ** DATA_W) + 0.5);

    // Reset state
    tick(); tick(); tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_phase", 32'(phase_out), 32'd0);
`ifdef PHASE_RECOVER_MAG_EN
    check_eq("rst_mag", 32'(mag_out), 32'd0);
`endif
    rst = 1'b1;
    tick();

    // Cardinal and diagonal directions
    run_pair(0, 16384, ph, mg, lat);
    check_near("ph_0deg", ph, 16'h0000, 2);
    check_eq("lat_0deg", 32'(lat), 32'(LAT));
    check_eq("post_hs_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_hs_out_valid", 32'(out_valid), 32'd0);
`ifdef PHASE_RECOVER_MAG_EN
    check_near("mag_0deg", mg, 16'd26981, 4);
`endif
    run_pair(16384, 0, ph, mg, lat);
    check_near("ph_90deg", ph, 16'h4000, 2);
    check_eq("lat_90deg", 32'(lat), 32'(LAT));
    run_pair(0, -16384, ph, mg, lat);
    check_near("ph_180deg", ph, 16'h8000, 2);
    run_pair(-11585, 11585, ph, mg, lat);
    check_near("ph_315deg", ph, 16'hE000, 2);
    run_pair(-1, 16384, ph, mg, lat);
    check_near("ph_wrap", ph, 16'h0000, 2);
    run_pair(-16384, -1, ph, mg, lat);
    check_near("ph_270deg", ph, 16'hC000, 2);
    run_pair(0, 0, ph, mg, lat);
    check_eq("ph_zero_in", 32'(ph), 32'd0);
    check_eq("lat_zero_in", 32'(lat), 32'(LAT));

    // Stall in DONE with in_valid pulses that must be ignored
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    sin_in = 16'd16384; cos_in = 16'd0; in_valid = 1'b1;
    tick();
    sin_in = DATA_W'(0); cos_in = DATA_W'(-16384);
    tick(); tick();
    check_eq("run_in_ready", 32'(in_ready), 32'd0);
    guard = 0;
    while (out_valid !== 1'b1 && guard < 4 * LAT) begin tick(); guard++; end
    check_eq("stall_valid_seen", 32'(out_valid), 32'd1);
    ph0 = phase_out;
    check_near("stall_phase", ph0, 16'h4000, 2);
    for (int k = 0; k < 5; k++) begin
      sin_in   = DATA_W'($urandom);
      cos_in   = DATA_W'($urandom);
      in_valid = k[0];
      tick();
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_phase_hold", 32'(phase_out), 32'(ph0));
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("stall_release", 32'(out_valid), 32'd0);
    run_pair(0, 16384, ph, mg, lat);
    check_near("after_stall", ph, 16'h0000, 2);

    // Randomized pairs against the reference model
    for (int n = 0; n < 24; n++) begin
      if (n[0]) begin
        real a, amp;
        amp = real'($urandom_range(16384, 2048));
        a   = 2.0 * PI * real'($urandom_range(65535)) / 65536.0;
        s   = $rtoi(amp * $sin(a));
        c   = $rtoi(amp * $cos(a));
      end else begin
        s = int'($urandom_range(32768)) - 16384;
        c = int'($urandom_range(32768)) - 16384;
      end
      ref_model(s, c, eph, emg);
      run_pair(s, c, ph, mg, lat);
      check_eq($sformatf("rand_ph s=%0d c=%0d", s, c), 32'(ph), 32'(eph));
      check_eq("rand_lat", 32'(lat), 32'(LAT));
`ifdef PHASE_RECOVER_MAG_EN
      check_eq($sformatf("rand_mag s=%0d c=%0d", s, c), 32'(mg), 32'(emg));
`endif
    end

    // Reset on RUN cycle 3 aborts the operation
    run_pair(16384, 0, ph, mg, lat);
    check_near("pre_abort", ph, 16'h4000, 2);
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    sin_in = DATA_W'(0); cos_in = DATA_W'(-16384); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_phase", 32'(phase_out), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int k = 0; k < LAT + 5; k++) begin
      tick();
      seen_valid = seen_valid | out_valid;
    end
    check_eq("abort_no_valid", 32'(seen_valid), 32'd0);
    run_pair(-11585, 11585, ph, mg, lat);
    check_near("post_abort_ph", ph, 16'hE000, 2);
    check_eq("post_abort_lat", 32'(lat), 32'(LAT));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
